// File: rtl/state_reg_bank.sv
// -----------------------------------------------------------------------------
// state_reg_bank
//   SKINNY/Romulus cipher-state register with a lane-serial load path.
//   The global enable gates every register. Each enabled cycle performs exactly
//   one action: parallel load of si, round update from skinnys, synchronous
//   clear to INIT, or one beat of a LANES-beat serial absorb of LANE_W-bit words
//   using a valid/ready handshake. The block sits between the datapath mux and
//   the SKINNY round function.
//
// Parameters
//   WIDTH   state width in bits (default 128)
//   LANE_W  serial word width; WIDTH must be a multiple of LANE_W (default 8)
//   INIT    WIDTH-bit value loaded on reset and on clr (default 0)
//   LANES   (derived, localparam) WIDTH/LANE_W beats per serial load
//
// Ports
//   clk        in   1       clock
//   rst        in   1       asynchronous active-low reset (0 = reset)
//   en         in   1       global enable; 0 holds all registers, no handshake
//   clr        in   1       synchronous clear to INIT, aborts a serial load
//   se         in   1       1 = parallel load si, 0 = round update skinnys
//   si         in   WIDTH   parallel load data
//   skinnys    in   WIDTH   round-function output
//   ser_start  in   1       begin a serial load (sampled in IDLE)
//   ser_in     in   LANE_W  serial word
//   ser_valid  in   1       ser_in valid
//   ser_ready  out  1       ser_in is accepted this cycle
//   busy       out  1       serial load in progress
//   done       out  1       pulse after the last serial beat is accepted
//   so         out  WIDTH   registered state
//
// Build option
//   STATE_REG_BANK_ICG_EN  when defined, the so/cnt/state flops run on a
//                          latch-based gated clock instead of using en as a
//                          flop enable. Port-level cycle behaviour is the same.
// -----------------------------------------------------------------------------
module state_reg_bank #(
  parameter int unsigned        WIDTH  = 128,
  parameter int unsigned        LANE_W = 8,
  parameter logic [WIDTH-1:0]   INIT   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              se,
  input  logic [WIDTH-1:0]  si,
  input  logic [WIDTH-1:0]  skinnys,
  input  logic              ser_start,
  input  logic [LANE_W-1:0] ser_in,
  input  logic              ser_valid,
  output logic              ser_ready,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  so
);

  localparam int unsigned LANES = WIDTH / LANE_W;
  localparam int unsigned CW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(LANES - 1);

  typedef enum logic {
    S_IDLE,
    S_SERIAL
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] so_q, so_d;
  logic [WIDTH-1:0] so_shift;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             beat;
  logic             last_beat;

  // Handshake: only in SERIAL, only when enabled, and never on a clear cycle
  // so that an aborting clr cannot also swallow a word.
  assign ser_ready = (state_q == S_SERIAL) & en & ~clr;
  assign beat      = ser_ready & ser_valid;
  assign last_beat = beat & (cnt_q == LAST_BEAT);

  assign busy = (state_q == S_SERIAL);
  assign done = done_q;
  assign so   = so_q;

  // Shift a new word into the LSB lane; the first word ends up in the MSB lane
  // after LANES beats. A single-lane configuration simply replaces the state.
  generate
    if (LANES == 1) begin : g_one_lane
      assign so_shift = WIDTH'(ser_in);
    end else begin : g_multi_lane
      assign so_shift = {so_q[WIDTH-LANE_W-1:0], ser_in};
    end
  endgenerate

  // Next-state logic assumes an enabled cycle; en is applied at the registers
  // (flop enable or gated clock) so both builds share this block.
  always_comb begin
    so_d    = so_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (clr) begin
          so_d = INIT;
        end else if (ser_start) begin
          state_d = S_SERIAL;
          cnt_d   = '0;
        end else if (se) begin
          so_d = si;
        end else begin
          so_d = skinnys;
        end
      end

      S_SERIAL: begin
        if (clr) begin
          so_d    = INIT;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (beat) begin
          so_d = so_shift;
          if (last_beat) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef STATE_REG_BANK_ICG_EN
  // Latch-based clock gate: en is captured while clk is low so gclk cannot
  // glitch during the high phase.
  logic en_lat;
  logic gclk;

  always_latch begin
    if (!clk) begin
      en_lat <= en;
    end
  end

  assign gclk = en_lat & clk;

  always_ff @(posedge gclk or negedge rst) begin
    if (!rst) begin
      so_q    <= INIT;
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      so_q    <= so_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      so_q    <= INIT;
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else if (en) begin
      so_q    <= so_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`endif

  // done stays on the free-running clock in both builds; it holds while en=0
  // and drops on the first enabled edge after it fires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
    end else if (en) begin
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_state_reg_bank.sv
module tb_state_reg_bank;

  localparam int W  = 128;
  localparam int LW = 8;
  localparam int LN = W / LW;
  localparam logic [W-1:0] INITV  = 128'h0F;
  localparam logic [W-1:0] SER_EXP = 128'h000102030405060708090A0B0C0D0E0F;

  logic          clk = 1'b0;
  logic          rst;
  logic          en, clr, se, ser_start, ser_valid;
  logic [W-1:0]  si, skinnys;
  logic [LW-1:0] ser_in;
  logic          ser_ready, busy, done;
  logic [W-1:0]  so;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  state_reg_bank #(
    .WIDTH (W),
    .LANE_W(LW),
    .INIT  (INITV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (clr),
    .se       (se),
    .si       (si),
    .skinnys  (skinnys),
    .ser_start(ser_start),
    .ser_in   (ser_in),
    .ser_valid(ser_valid),
    .ser_ready(ser_ready),
    .busy     (busy),
    .done     (done),
    .so       (so)
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: a mode flag, the state value and the list of words
  // absorbed in the current serial load.
  bit           m_ser;
  bit           m_done;
  logic [W-1:0] m_so;
  byte unsigned m_q[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ser  = 1'b0;
      m_done = 1'b0;
      m_so   = INITV;
      m_q.delete();
    end else if (en) begin
      m_done = 1'b0;
      if (!m_ser) begin
        if (clr)            m_so = INITV;
        else if (ser_start) begin m_ser = 1'b1; m_q.delete(); end
        else if (se)        m_so = si;
        else                m_so = skinnys;
      end else begin
        if (clr) begin
          m_so  = INITV;
          m_ser = 1'b0;
        end else if (ser_valid) begin
          m_so = (m_so << LW) | W'(ser_in);
          m_q.push_back(ser_in);
          if (m_q.size() == LN) begin
            m_ser  = 1'b0;
            m_done = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic [W-1:0] pv;
    chk("so", so, m_so);
    chk("busy", busy, W'(m_ser));
    chk("ser_ready", ser_ready, W'(m_ser && en && !clr));
    chk("done", done, W'(m_done));
    if (m_done) begin
      pv = '0;
      foreach (m_q[i]) pv = (pv << LW) | W'(m_q[i]);
      chk("serial_pack", so, pv);
    end
  end

  task automatic idle_inputs();
    en = 1'b0; clr = 1'b0; se = 1'b0; ser_start = 1'b0; ser_valid = 1'b0;
    si = '0; skinnys = '0; ser_in = '0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();

    // Reset state
    repeat (2) step();
    chk("rst_so", so, INITV);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ser_ready, 0);
    chk("rst_done", done, 0);
    rst = 1'b1;

    // Parallel load then round update
    en = 1'b1; se = 1'b1; si = {16{8'hA5}};
    step();
    chk("par_load", so, {16{8'hA5}});
    se = 1'b0; skinnys = 128'h1234;
    step();
    chk("round", so, 128'h1234);

    // Uninterrupted serial load
    ser_start = 1'b1;
    step();
    chk("start_hold_so", so, 128'h1234);
    chk("start_busy", busy, 1);
    ser_start = 1'b0;
    for (int i = 0; i < LN; i++) begin
      ser_in = 8'(i); ser_valid = 1'b1;
      step();
    end
    chk("ser_so", so, SER_EXP);
    chk("ser_done", done, 1);
    chk("ser_busy_end", busy, 0);
    ser_valid = 1'b0; se = 1'b1; si = SER_EXP;
    step();
    chk("done_one_cycle", done, 0);

    // Serial load with valid gaps and enable stalls
    se = 1'b0; ser_start = 1'b1;
    step();
    ser_start = 1'b0;
    for (int i = 0; i < LN; i++) begin
      if (i == 5) begin
        ser_valid = 1'b0;
        repeat (3) step();
      end
      if (i == 9) begin
        en = 1'b0; ser_valid = 1'b1; ser_in = 8'hEE;
        repeat (2) begin
          step();
          chk("stall_ready", ser_ready, 0);
        end
        en = 1'b1;
      end
      ser_in = 8'(i); ser_valid = 1'b1;
      step();
    end
    chk("stall_so", so, SER_EXP);
    chk("stall_done", done, 1);
    ser_valid = 1'b0; se = 1'b1; si = SER_EXP;
    step();

    // Abort with clr after 7 beats
    se = 1'b0; ser_start = 1'b1;
    step();
    ser_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ser_in = 8'(8'h40 + i); ser_valid = 1'b1;
      step();
    end
    clr = 1'b1;
    step();
    chk("abort_so", so, INITV);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    clr = 1'b0; ser_valid = 1'b0; se = 1'b1; si = INITV;
    step();
    chk("abort_no_done", done, 0);

    // Async reset between edges mid-serial
    se = 1'b0; ser_start = 1'b1;
    step();
    ser_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ser_in = 8'(8'h80 + i); ser_valid = 1'b1;
      step();
    end
    #2 rst = 1'b0;
    #1;
    chk("async_so", so, INITV);
    chk("async_busy", busy, 0);
    chk("async_ready", ser_ready, 0);
    rst = 1'b1;
    ser_valid = 1'b0;

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      en        = ($urandom_range(0, 9) != 0);
      clr       = ($urandom_range(0, 39) == 0);
      ser_start = ($urandom_range(0, 5) == 0);
      se        = 1'($urandom_range(0, 1));
      si        = {$urandom, $urandom, $urandom, $urandom};
      skinnys   = {$urandom, $urandom, $urandom, $urandom};
      ser_in    = 8'($urandom);
      ser_valid = ($urandom_range(0, 9) < 7);
      step();
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b0;
        #1;
        chk("rand_async_so", so, INITV);
        rst = 1'b1;
      end
    end

    idle_inputs();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
